c5_ram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, byte-writable block RAM (one-cycle registered read latency) between the instruction-fetch port (port 0) and the load/store port (port 1) of the c5 core. It accepts strobe-based requests, grants one per access slot, drives the RAM strobe/write-enable/address/data, and returns a single-cycle acknowledge with read data to the granted requester. It sits between the core's memory ports and the RAM instance in the SoC top.

---
 rtl/c5_arb_pkg.sv | 14 +
 rtl/c5_ram_arbiter_if.sv | 46 ++++
 rtl/c5_rr_pick.sv | 32 +++
 rtl/c5_ram_arbiter.sv | 98 +++++++++
 tb/tb_c5_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c5_arb_pkg.sv
// c5_arb_pkg: shared state type and port constants for the c5 RAM arbiter.
package c5_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_LS  = 1'b1;
   // Last-winner pointer after reset: pointing at port 1 favours port 0 first.
   localparam logic RST_LAST = 1'b1;

endpackage

// File: rtl/c5_ram_arbiter_if.sv
// c5_ram_arbiter_if: requester, RAM and status signals of the c5 RAM arbiter.
interface c5_ram_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int ADR_W = 32
);
   logic             I_m0_stb;
   logic [3:0]       I_m0_we;
   logic [ADR_W-1:0] I_m0_adr;
   logic [WIDTH-1:0] I_m0_dat;
   logic             O_m0_ack;
   logic [WIDTH-1:0] O_m0_dat;

   logic             I_m1_stb;
   logic [3:0]       I_m1_we;
   logic [ADR_W-1:0] I_m1_adr;
   logic [WIDTH-1:0] I_m1_dat;
   logic             O_m1_ack;
   logic [WIDTH-1:0] O_m1_dat;

   logic             O_ram_stb;
   logic [3:0]       O_ram_we;
   logic [ADR_W-1:0] O_ram_adr;
   logic [WIDTH-1:0] O_ram_dat;
   logic [WIDTH-1:0] I_ram_dat;

   logic             O_busy;

   modport slave (
      input  I_m0_stb, I_m0_we, I_m0_adr, I_m0_dat,
      input  I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat,
      input  I_ram_dat,
      output O_m0_ack, O_m0_dat, O_m1_ack, O_m1_dat,
      output O_ram_stb, O_ram_we, O_ram_adr, O_ram_dat,
      output O_busy
   );

   modport master (
      output I_m0_stb, I_m0_we, I_m0_adr, I_m0_dat,
      output I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat,
      output I_ram_dat,
      input  O_m0_ack, O_m0_dat, O_m1_ack, O_m1_dat,
      input  O_ram_stb, O_ram_we, O_ram_adr, O_ram_dat,
      input  O_busy
   );

endinterface

// File: rtl/c5_rr_pick.sv
// c5_rr_pick: two-way request picker. C5_ARB_RR_EN selects round-robin ties;
// without it port 1 (load/store) always wins a tie.
module c5_rr_pick
   import c5_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   assign gnt_valid = |req;

`ifdef C5_ARB_RR_EN
   always_comb begin
      gnt_idx = PORT_IF;
      if (req == 2'b11) begin
         gnt_idx = ~last;
      end else if (req[1]) begin
         gnt_idx = PORT_LS;
      end
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      gnt_idx = req[1] ? PORT_LS : PORT_IF;
   end
`endif

endmodule

// File: rtl/c5_ram_arbiter.sv
// c5_ram_arbiter: shares one single-port byte-writable RAM between instruction fetch
// (port 0) and load/store (port 1). Define C5_ARB_RR_EN for round-robin tie-breaking.
module c5_ram_arbiter
   import c5_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ADR_W = 32
) (
   input logic             I_clk,
   input logic             I_rst_n,
   c5_ram_arbiter_if.slave bus
);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic             last_q;
   logic             gnt_valid, gnt_idx, issue;

   logic             ram_stb;
   logic [3:0]       ram_we;
   logic [ADR_W-1:0] ram_adr;
   logic [WIDTH-1:0] ram_dat;

   c5_rr_pick u_pick (
      .req       ({bus.I_m1_stb, bus.I_m0_stb}),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Never grant while reset is held, so a reset cycle cannot start a RAM access.
   assign issue = (state_q == IDLE) && gnt_valid && I_rst_n;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_q <= IDLE;
         owner_q <= PORT_IF;
         adr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         adr_q   <= adr_d;
      end
   end

`ifdef C5_ARB_RR_EN
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         last_q <= RST_LAST;
      end else if (issue) begin
         last_q <= gnt_idx;
      end
   end
`else
   assign last_q = RST_LAST;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      adr_d   = adr_q;
      ram_stb = 1'b0;
      ram_we  = 4'b0000;
      ram_adr = adr_q;
      ram_dat = '0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               ram_stb = 1'b1;
               ram_we  = gnt_idx ? bus.I_m1_we  : bus.I_m0_we;
               ram_adr = gnt_idx ? bus.I_m1_adr : bus.I_m0_adr;
               ram_dat = gnt_idx ? bus.I_m1_dat : bus.I_m0_dat;
               owner_d = gnt_idx;
               adr_d   = ram_adr;
               state_d = BUSY;
            end
         end
         BUSY:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.O_ram_stb = ram_stb;
   assign bus.O_ram_we  = ram_we;
   assign bus.O_ram_adr = ram_adr;
   assign bus.O_ram_dat = ram_dat;

   // Acks come from registered state; reset suppresses the ack of an abandoned access.
   assign bus.O_m0_ack = (state_q == BUSY) && I_rst_n && (owner_q == PORT_IF);
   assign bus.O_m1_ack = (state_q == BUSY) && I_rst_n && (owner_q == PORT_LS);
   assign bus.O_m0_dat = bus.I_ram_dat;
   assign bus.O_m1_dat = bus.I_ram_dat;
   assign bus.O_busy   = (state_q == BUSY);

endmodule

// File: tb/tb_c5_ram_arbiter.sv
// tb_c5_ram_arbiter: table-driven, directed and randomized checks of c5_ram_arbiter;
// expectations follow C5_ARB_RR_EN when the bench is built with it.
module tb_c5_ram_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic reload = 1'b0;

   c5_ram_arbiter_if bus ();

   c5_ram_arbiter dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

`ifdef C5_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;

   function automatic logic [31:0] preload(input int i);
      return 32'hA500_0000 | 32'(i);
   endfunction

   // RAM with one-cycle registered read, byte writes, and a bulk reload used at reset.
   logic [31:0] ram [0:255];
   always @(posedge clk) begin
      if (reload) begin
         for (int i = 0; i < 256; i++) ram[i] <= preload(i);
      end else if (bus.O_ram_stb) begin
         bus.I_ram_dat <= ram[bus.O_ram_adr[9:2]];
         for (int b = 0; b < 4; b++)
            if (bus.O_ram_we[b]) ram[bus.O_ram_adr[9:2]][8*b +: 8] <= bus.O_ram_dat[8*b +: 8];
      end
   end

   logic [31:0] ref_mem [0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_port(input int p, input logic s, input logic [3:0] we,
                             input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         bus.I_m0_stb = s; bus.I_m0_we = we; bus.I_m0_adr = a; bus.I_m0_dat = d;
      end else begin
         bus.I_m1_stb = s; bus.I_m1_we = we; bus.I_m1_adr = a; bus.I_m1_dat = d;
      end
   endtask

   task automatic idle_inputs();
      drive_port(0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n  = 1'b0;
      reload = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
      @(posedge clk); #1;
      reload = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One table record: inputs for both ports plus the expected grant and read data.
   typedef struct {
      logic        s0;  logic [3:0] we0; logic [31:0] a0; logic [31:0] d0;
      logic        s1;  logic [3:0] we1; logic [31:0] a1; logic [31:0] d1;
      logic        exp_stb;
      logic        exp_port;
      logic        chk_dat;
      logic [31:0] exp_dat;
   } vec_t;

   function automatic vec_t mk(input logic s0, input logic [3:0] we0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic s1, input logic [3:0] we1,
                               input logic [31:0] a1, input logic [31:0] d1, input logic es,
                               input logic ep, input logic cd, input logic [31:0] ed);
      vec_t v;
      v.s0 = s0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
      v.s1 = s1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
      v.exp_stb = es; v.exp_port = ep; v.chk_dat = cd; v.exp_dat = ed;
      return v;
   endfunction

   vec_t tbl [8];

   typedef struct {
      logic        port;
      logic        rd;
      logic [31:0] dat;
   } pend_t;

   pend_t       pend [$];
   logic        m_last;
   logic        r_stb [2];
   logic [3:0]  r_we  [2];
   logic [31:0] r_adr [2];
   logic [31:0] r_dat [2];

   initial begin
      logic        w;
      logic [3:0]  ewe;
      logic [31:0] eadr, edat;
      logic        acked [2];
      pend_t       p;

      // Records run back to back after reset, so round-robin ties depend on prior grants.
      tbl[0] = mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hA500_0004);
      tbl[1] = mk(0, 4'h0, 32'h0, 32'h0, 1, 4'b0011, 32'h20, 32'hDEAD_BEEF, 1, 1, 0, 32'h0);
      tbl[2] = mk(1, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'hA500_BEEF);
      tbl[3] = mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h24, 32'h0, 1, 1, 1, 32'hA500_0009);
      tbl[4] = mk(1, 4'h0, 32'h30, 32'h0, 1, 4'h0, 32'h34, 32'h0, 1, RR ? 1'b0 : 1'b1, 1,
                  RR ? 32'hA500_000C : 32'hA500_000D);
      tbl[5] = mk(1, 4'b1000, 32'h40, 32'hFF00_0000, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
      tbl[6] = mk(1, 4'h0, 32'h50, 32'h0, 1, 4'h0, 32'h40, 32'h0, 1, 1, 1, 32'hFF00_0010);
      tbl[7] = mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_ram_stb", 32'(bus.O_ram_stb), 32'd0);
      check("rst_ram_we",  32'(bus.O_ram_we),  32'd0);
      check("rst_ram_adr", bus.O_ram_adr, 32'd0);
      check("rst_ram_dat", bus.O_ram_dat, 32'd0);
      check("rst_ack0",    32'(bus.O_m0_ack), 32'd0);
      check("rst_ack1",    32'(bus.O_m1_ack), 32'd0);
      check("rst_busy",    32'(bus.O_busy),   32'd0);
      @(posedge clk); #1;

      // Table-driven single transactions
      for (int i = 0; i < 8; i++) begin
         drive_port(0, tbl[i].s0, tbl[i].we0, tbl[i].a0, tbl[i].d0);
         drive_port(1, tbl[i].s1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
         @(negedge clk);
         check("tbl_issue_stb", 32'(bus.O_ram_stb), 32'(tbl[i].exp_stb));
         check("tbl_issue_busy", 32'(bus.O_busy), 32'd0);
         if (tbl[i].exp_stb) begin
            check("tbl_issue_we",  32'(bus.O_ram_we),
                  32'(tbl[i].exp_port ? tbl[i].we1 : tbl[i].we0));
            check("tbl_issue_adr", bus.O_ram_adr, tbl[i].exp_port ? tbl[i].a1 : tbl[i].a0);
            check("tbl_issue_dat", bus.O_ram_dat, tbl[i].exp_port ? tbl[i].d1 : tbl[i].d0);
         end
         @(posedge clk); #1;
         @(negedge clk);
         check("tbl_ack0", 32'(bus.O_m0_ack), 32'(tbl[i].exp_stb && !tbl[i].exp_port));
         check("tbl_ack1", 32'(bus.O_m1_ack), 32'(tbl[i].exp_stb && tbl[i].exp_port));
         check("tbl_busy", 32'(bus.O_busy),   32'(tbl[i].exp_stb));
         check("tbl_ack_ram_stb", 32'(bus.O_ram_stb), 32'd0);
         if (tbl[i].chk_dat)
            check("tbl_rdata", tbl[i].exp_port ? bus.O_m1_dat : bus.O_m0_dat, tbl[i].exp_dat);
         @(posedge clk); #1;
         idle_inputs();
      end

      // Both ports requesting continuously: 8 accesses in 16 cycles
      do_reset();
      drive_port(0, 1'b1, 4'h0, 32'h10, 32'h0);
      drive_port(1, 1'b1, 4'h0, 32'h14, 32'h0);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c % 2 == 1) begin
            w = RR ? 1'(((c - 1) / 2) % 2) : 1'b1;
            check("cont_ack0", 32'(bus.O_m0_ack), 32'(!w));
            check("cont_ack1", 32'(bus.O_m1_ack), 32'(w));
         end else begin
            check("cont_gap_ack", 32'(bus.O_m0_ack | bus.O_m1_ack), 32'd0);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;

      // Reset during BUSY abandons the access; the held request is reissued afterwards
      drive_port(0, 1'b1, 4'h0, 32'h18, 32'h0);
      @(negedge clk);
      check("rstbusy_issue_adr", bus.O_ram_adr, 32'h18);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rstbusy_ack0", 32'(bus.O_m0_ack), 32'd0);
      check("rstbusy_ack1", 32'(bus.O_m1_ack), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstbusy_busy_after", 32'(bus.O_busy), 32'd0);
      check("rstbusy_reissue_stb", 32'(bus.O_ram_stb), 32'd1);
      check("rstbusy_reissue_adr", bus.O_ram_adr, 32'h18);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstbusy_ack0_late", 32'(bus.O_m0_ack), 32'd1);
      check("rstbusy_rdata", bus.O_m0_dat, 32'hA500_0006);
      @(posedge clk); #1;
      idle_inputs();

      // Port 0 loses a tie (last winner is port 0 in either mode), then drops its strobe
      drive_port(0, 1'b1, 4'h0, 32'h1C, 32'h0);
      drive_port(1, 1'b1, 4'h0, 32'h2C, 32'h0);
      @(negedge clk);
      check("pulse_issue_adr", bus.O_ram_adr, 32'h2C);
      @(posedge clk); #1;
      drive_port(0, 1'b0, 4'h0, 32'h1C, 32'h0);
      @(negedge clk);
      check("pulse_ack1", 32'(bus.O_m1_ack), 32'd1);
      check("pulse_ack0", 32'(bus.O_m0_ack), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("pulse_no_access", 32'(bus.O_ram_stb), 32'd0);
         check("pulse_no_ack0",   32'(bus.O_m0_ack),  32'd0);
         @(posedge clk); #1;
      end

      // Randomized traffic against a transaction-level reference model
      do_reset();
      pend.delete();
      m_last = 1'b1;
      for (int k = 0; k < 2; k++) begin
         r_stb[k] = 1'b0; r_we[k] = 4'h0; r_adr[k] = 32'h0; r_dat[k] = 32'h0;
      end
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acked[0] = 1'b0;
         acked[1] = 1'b0;
         if (pend.size() > 0) begin
            p = pend.pop_front();
            check("rnd_ack0", 32'(bus.O_m0_ack), 32'(!p.port));
            check("rnd_ack1", 32'(bus.O_m1_ack), 32'(p.port));
            check("rnd_busy", 32'(bus.O_busy), 32'd1);
            check("rnd_busy_stb", 32'(bus.O_ram_stb), 32'd0);
            if (p.rd) check("rnd_rdata", p.port ? bus.O_m1_dat : bus.O_m0_dat, p.dat);
            acked[p.port] = 1'b1;
         end else if (!r_stb[0] && !r_stb[1]) begin
            check("rnd_idle_stb", 32'(bus.O_ram_stb), 32'd0);
            check("rnd_idle_ack", 32'(bus.O_m0_ack | bus.O_m1_ack), 32'd0);
            check("rnd_idle_busy", 32'(bus.O_busy), 32'd0);
         end else begin
            w = (r_stb[0] && r_stb[1]) ? (RR ? ~m_last : 1'b1) : r_stb[1];
            ewe  = r_we[w];
            eadr = r_adr[w];
            edat = r_dat[w];
            check("rnd_stb", 32'(bus.O_ram_stb), 32'd1);
            check("rnd_we",  32'(bus.O_ram_we), 32'(ewe));
            check("rnd_adr", bus.O_ram_adr, eadr);
            check("rnd_dat", bus.O_ram_dat, edat);
            check("rnd_issue_ack", 32'(bus.O_m0_ack | bus.O_m1_ack), 32'd0);
            p.port = w;
            p.rd   = (ewe == 4'h0);
            p.dat  = ref_mem[eadr[9:2]];
            pend.push_back(p);
            for (int b = 0; b < 4; b++)
               if (ewe[b]) ref_mem[eadr[9:2]][8*b +: 8] = edat[8*b +: 8];
            m_last = w;
         end
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (acked[k]) r_stb[k] = 1'b0;
            if (!r_stb[k] && ($urandom_range(0, 2) == 0)) begin
               r_stb[k] = 1'b1;
               r_we[k]  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
               r_adr[k] = 32'($urandom_range(0, 255));
               r_dat[k] = $urandom;
            end
            drive_port(k, r_stb[k], r_we[k], r_adr[k], r_dat[k]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
